spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// Turns a stream of SPI words into register-bus transactions. The first word
// of a frame is a command (bit DATA_W-1 = read, bit DATA_W-2 = auto-increment,
// low ADDR_W bits = start address). Writes take one data word per bus write.
// Reads fetch a bus word, hand it to the shifter through tx_data/tx_load, and
// fetch the next one each time the shifter reports a completed word.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   frame_start/end    one-cycle pulses on SS assert / deassert
//   rx_data, rx_valid  received word and its one-cycle strobe
//   tx_data, tx_load   registered word to shift out and its one-cycle strobe
//   bus_req/we/addr/wdata, bus_ack/rdata   register-bus request/completion
//   word_cnt           data words completed in this frame (saturating)
//   overrun            sticky: a word arrived while a bus access was pending
//   busy               state is not IDLE
//   state_dbg          current FSM state encoding
//
// Bus handshake: bus_req rises together with stable bus_we/bus_addr/bus_wdata
// and stays high, with those fields unchanged, until the cycle in which
// bus_ack is seen high; bus_req drops on the following cycle. bus_ack is
// ignored whenever bus_req is low.
module spi_cmd_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              overrun,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    WR_BUS  = 3'd3,
    RD_BUS  = 3'd4,
    RD_WAIT = 3'd5
  } state_t;

  state_t state, state_d;

  logic rnw;
  logic incr;
  logic pend_end;

  // Control strobes decoded together with the next state so the datapath
  // register block cannot disagree with the transition taken.
  logic start_frame;
  logic cmd_take;
  logic data_take;
  logic rd_issue;
  logic bus_done;
  logic set_pend;
  logic set_ovr;

  always_comb begin
    state_d     = state;
    start_frame = 1'b0;
    cmd_take    = 1'b0;
    data_take   = 1'b0;
    rd_issue    = 1'b0;
    bus_done    = 1'b0;
    set_pend    = 1'b0;
    set_ovr     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          state_d     = CMD;
        end
      end
      CMD: begin
        // A command that arrives together with frame_end is dropped.
        if (frame_end) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          cmd_take = 1'b1;
          state_d  = rx_data[DATA_W-1] ? RD_BUS : DATA;
        end
      end
      DATA: begin
        // A data word arriving with frame_end is still written; the end is
        // remembered and honoured once the write completes.
        if (rx_valid) begin
          data_take = 1'b1;
          set_pend  = frame_end;
          state_d   = WR_BUS;
        end else if (frame_end) begin
          state_d = IDLE;
        end
      end
      WR_BUS, RD_BUS: begin
        set_pend = frame_end;
        set_ovr  = rx_valid;
        if (bus_ack) begin
          bus_done = 1'b1;
          if (pend_end || frame_end) begin
            state_d = IDLE;
          end else begin
            state_d = rnw ? RD_WAIT : DATA;
          end
        end
      end
      RD_WAIT: begin
        if (frame_end) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          rd_issue = 1'b1;
          state_d  = RD_BUS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data   <= '0;
      tx_load   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      word_cnt  <= '0;
      overrun   <= 1'b0;
      rnw       <= 1'b0;
      incr      <= 1'b0;
      pend_end  <= 1'b0;
    end else begin
      tx_load <= 1'b0;

      if (start_frame) begin
        word_cnt <= '0;
        overrun  <= 1'b0;
        pend_end <= 1'b0;
      end

      if (cmd_take) begin
        rnw      <= rx_data[DATA_W-1];
        incr     <= rx_data[DATA_W-2];
        bus_addr <= rx_data[ADDR_W-1:0];
        if (rx_data[DATA_W-1]) begin
          bus_req <= 1'b1;
          bus_we  <= 1'b0;
        end
      end

      if (data_take) begin
        bus_wdata <= rx_data;
        bus_req   <= 1'b1;
        bus_we    <= 1'b1;
      end

      // In RD_WAIT the incoming word is only a "shifted out" marker.
      if (rd_issue) begin
        bus_req <= 1'b1;
        bus_we  <= 1'b0;
      end

      if (set_pend) begin
        pend_end <= 1'b1;
      end

      if (set_ovr) begin
        overrun <= 1'b1;
      end

      if (bus_done) begin
        bus_req  <= 1'b0;
        bus_addr <= bus_addr + ADDR_W'(incr);
        if (word_cnt != {CNT_W{1'b1}}) begin
          word_cnt <= word_cnt + CNT_W'(1);
        end
        if (state == RD_BUS) begin
          tx_data <= bus_rdata;
          tx_load <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_load;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic [CW-1:0] word_cnt;
  logic          overrun;
  logic          busy;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  spi_cmd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .word_cnt    (word_cnt),
    .overrun     (overrun),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- vector table
  typedef struct {
    string       name;
    bit          fs, fe, rv;
    logic [31:0] rd;
    bit          ack;
    logic [31:0] rdata;
    bit          e_busy, e_req, e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    bit          e_load;
    logic [31:0] e_tx;
    logic [7:0]  e_cnt;
    bit          e_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input string name, input bit fs, input bit fe, input bit rv,
                               input logic [31:0] rd, input bit ack, input logic [31:0] rdata,
                               input bit busy_e, input bit req_e, input bit we_e,
                               input logic [7:0] addr_e, input logic [31:0] wdata_e,
                               input bit load_e, input logic [31:0] tx_e,
                               input logic [7:0] cnt_e, input bit ovr_e);
    vec_t v;
    v.name = name; v.fs = fs; v.fe = fe; v.rv = rv; v.rd = rd; v.ack = ack; v.rdata = rdata;
    v.e_busy = busy_e; v.e_req = req_e; v.e_we = we_e; v.e_addr = addr_e; v.e_wdata = wdata_e;
    v.e_load = load_e; v.e_tx = tx_e; v.e_cnt = cnt_e; v.e_ovr = ovr_e;
    return v;
  endfunction

  // ---------------- scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input bit busy_e, input bit req_e, input bit we_e,
                         input logic [7:0] addr_e, input logic [31:0] wdata_e, input bit load_e,
                         input logic [31:0] tx_e, input logic [7:0] cnt_e, input bit ovr_e);
    chk({name, ".busy"},  32'(busy),      32'(busy_e));
    chk({name, ".req"},   32'(bus_req),   32'(req_e));
    chk({name, ".we"},    32'(bus_we),    32'(we_e));
    chk({name, ".addr"},  32'(bus_addr),  32'(addr_e));
    chk({name, ".wdata"}, bus_wdata,      wdata_e);
    chk({name, ".load"},  32'(tx_load),   32'(load_e));
    chk({name, ".tx"},    tx_data,        tx_e);
    chk({name, ".cnt"},   32'(word_cnt),  32'(cnt_e));
    chk({name, ".ovr"},   32'(overrun),   32'(ovr_e));
  endtask

  // ---------------- driver
  // Inputs change 1 time unit after a rising edge and are held for one cycle.
  task automatic cyc(input bit fs, input bit fe, input bit rv, input logic [31:0] rd,
                     input bit ack, input logic [31:0] rdata);
    frame_start = fs;
    frame_end   = fe;
    rx_valid    = rv;
    rx_data     = rd;
    bus_ack     = ack;
    bus_rdata   = rdata;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
    bus_ack     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, rx_data, 0, bus_rdata);
  endtask

  // ---------------- test
  initial begin
    // Burst write 0x10/0x11 with 3-cycle ack, then fixed read at 0xFF.
    //                 name       fs fe rv rd            ack rdata   busy req we addr  wdata load tx      cnt ovr
    tbl.push_back(mkv("bw_start", 1, 0, 0, 32'h0,        0, 32'h0,    1, 0, 0, 8'h00, 32'h0, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("bw_cmd",   0, 0, 1, 32'h4000_0010,0, 32'h0,    1, 0, 0, 8'h10, 32'h0, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("bw_d0",    0, 0, 1, 32'hA,        0, 32'h0,    1, 1, 1, 8'h10, 32'hA, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("bw_w0a",   0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 1, 8'h10, 32'hA, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("bw_w0b",   0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 1, 8'h10, 32'hA, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("bw_ack0",  0, 0, 0, 32'h0,        1, 32'h0,    1, 0, 1, 8'h11, 32'hA, 0, 32'h0,    1, 0));
    tbl.push_back(mkv("bw_d1",    0, 0, 1, 32'hB,        0, 32'h0,    1, 1, 1, 8'h11, 32'hB, 0, 32'h0,    1, 0));
    tbl.push_back(mkv("bw_w1a",   0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 1, 8'h11, 32'hB, 0, 32'h0,    1, 0));
    tbl.push_back(mkv("bw_w1b",   0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 1, 8'h11, 32'hB, 0, 32'h0,    1, 0));
    tbl.push_back(mkv("bw_ack1",  0, 0, 0, 32'h0,        1, 32'h0,    1, 0, 1, 8'h12, 32'hB, 0, 32'h0,    2, 0));
    tbl.push_back(mkv("bw_end",   0, 1, 0, 32'h0,        0, 32'h0,    0, 0, 1, 8'h12, 32'hB, 0, 32'h0,    2, 0));
    tbl.push_back(mkv("fr_start", 1, 0, 0, 32'h0,        0, 32'h0,    1, 0, 1, 8'h12, 32'hB, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("fr_cmd",   0, 0, 1, 32'h8000_00FF,0, 32'h0,    1, 1, 0, 8'hFF, 32'hB, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("fr_wait",  0, 0, 0, 32'h0,        0, 32'h0,    1, 1, 0, 8'hFF, 32'hB, 0, 32'h0,    0, 0));
    tbl.push_back(mkv("fr_ack0",  0, 0, 0, 32'h0,        1, 32'h1234, 1, 0, 0, 8'hFF, 32'hB, 1, 32'h1234, 1, 0));
    tbl.push_back(mkv("fr_hold",  0, 0, 0, 32'h0,        0, 32'h0,    1, 0, 0, 8'hFF, 32'hB, 0, 32'h1234, 1, 0));
    tbl.push_back(mkv("fr_next",  0, 0, 1, 32'hDEAD,     0, 32'h0,    1, 1, 0, 8'hFF, 32'hB, 0, 32'h1234, 1, 0));
    tbl.push_back(mkv("fr_ack1",  0, 0, 0, 32'h0,        1, 32'h5678, 1, 0, 0, 8'hFF, 32'hB, 1, 32'h5678, 2, 0));
    tbl.push_back(mkv("fr_end",   0, 1, 0, 32'h0,        0, 32'h0,    0, 0, 0, 8'hFF, 32'hB, 0, 32'h5678, 2, 0));

    // Reset state: asserted asynchronously, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk_all("reset", 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    chk_all("post_reset", 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].fs, tbl[i].fe, tbl[i].rv, tbl[i].rd, tbl[i].ack, tbl[i].rdata);
      chk_all(tbl[i].name, tbl[i].e_busy, tbl[i].e_req, tbl[i].e_we, tbl[i].e_addr,
              tbl[i].e_wdata, tbl[i].e_load, tbl[i].e_tx, tbl[i].e_cnt, tbl[i].e_ovr);
    end

    // Address wrap: incrementing write from 0xFF.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 32'h4000_00FF, 0, 32'h0);
    chk("wrap.addr_cmd", 32'(bus_addr), 32'hFF);
    cyc(0, 0, 1, 32'h1, 0, 32'h0);
    chk("wrap.req0", 32'(bus_req), 32'h1);
    chk("wrap.addr0", 32'(bus_addr), 32'hFF);
    cyc(0, 0, 0, 32'h0, 1, 32'h0);
    chk("wrap.addr_after0", 32'(bus_addr), 32'h00);
    cyc(0, 0, 1, 32'h2, 0, 32'h0);
    chk("wrap.req1", 32'(bus_req), 32'h1);
    chk("wrap.addr1", 32'(bus_addr), 32'h00);
    cyc(0, 0, 0, 32'h0, 1, 32'h0);
    chk("wrap.addr_after1", 32'(bus_addr), 32'h01);
    chk("wrap.cnt", 32'(word_cnt), 32'd2);
    cyc(0, 1, 0, 32'h0, 0, 32'h0);
    chk("wrap.idle", 32'(busy), 32'h0);

    // Overrun: extra word while the write waits 10 cycles for its ack.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 32'h4000_0020, 0, 32'h0);
    cyc(0, 0, 1, 32'h55, 0, 32'h0);
    chk("ovr.req", 32'(bus_req), 32'h1);
    chk("ovr.clear_before", 32'(overrun), 32'h0);
    cyc(0, 0, 1, 32'h66, 0, 32'h0);
    chk("ovr.set", 32'(overrun), 32'h1);
    chk("ovr.wdata_kept", bus_wdata, 32'h55);
    idle(8);
    chk("ovr.req_held", 32'(bus_req), 32'h1);
    cyc(0, 0, 0, 32'h0, 1, 32'h0);
    chk_all("ovr.ack", 1, 0, 1, 8'h21, 32'h55, 0, 32'h5678, 1, 1);
    idle(3);
    chk("ovr.no_second_write", 32'(bus_req), 32'h0);
    chk("ovr.cnt_one", 32'(word_cnt), 32'd1);
    cyc(0, 1, 0, 32'h0, 0, 32'h0);
    chk("ovr.sticky", 32'(overrun), 32'h1);
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    chk("ovr.cleared", 32'(overrun), 32'h0);
    chk("ovr.cnt_cleared", 32'(word_cnt), 32'h0);
    cyc(0, 1, 0, 32'h0, 0, 32'h0);

    // frame_end while a read is outstanding.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 32'h8000_0040, 0, 32'h0);
    cyc(0, 1, 0, 32'h0, 0, 32'h0);
    chk("rdend.req_held", 32'(bus_req), 32'h1);
    chk("rdend.busy", 32'(busy), 32'h1);
    idle(2);
    chk("rdend.req_held2", 32'(bus_req), 32'h1);
    cyc(0, 0, 0, 32'h0, 1, 32'h0000_CAFE);
    chk_all("rdend.ack", 0, 0, 0, 8'h40, 32'h55, 1, 32'h0000_CAFE, 1, 0);
    idle(1);
    chk("rdend.load_pulse", 32'(tx_load), 32'h0);
    chk("rdend.tx_hold", tx_data, 32'h0000_CAFE);

    // rx_valid together with frame_end in CMD: command dropped.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 1, 1, 32'h8000_0033, 0, 32'h0);
    chk_all("cmdend", 0, 0, 0, 8'h40, 32'h55, 0, 32'h0000_CAFE, 0, 0);
    idle(2);
    chk("cmdend.no_req", 32'(bus_req), 32'h0);

    // rx_valid together with frame_end in DATA: word written, then IDLE.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 32'h4000_0050, 0, 32'h0);
    cyc(0, 1, 1, 32'h77, 0, 32'h0);
    chk_all("dataend.wr", 1, 1, 1, 8'h50, 32'h77, 0, 32'h0000_CAFE, 0, 0);
    cyc(0, 0, 0, 32'h0, 1, 32'h0);
    chk_all("dataend.ack", 0, 0, 1, 8'h51, 32'h77, 0, 32'h0000_CAFE, 1, 0);

    // word_cnt saturation with a fixed address; frame_start inside a frame ignored.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0000_0003, 0, 32'h0);
    for (int i = 0; i < 260; i++) begin
      cyc(0, 0, 1, 32'(i), 0, 32'h0);
      cyc(0, 0, 0, 32'h0, 1, 32'h0);
      if (i == 254) chk("sat.reach", 32'(word_cnt), 32'd255);
    end
    chk("sat.cnt", 32'(word_cnt), 32'd255);
    chk("sat.addr_fixed", 32'(bus_addr), 32'h03);
    chk("sat.wdata", bus_wdata, 32'd259);
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    chk("sat.fs_ignored_cnt", 32'(word_cnt), 32'd255);
    chk("sat.fs_ignored_busy", 32'(busy), 32'h1);
    cyc(0, 1, 0, 32'h0, 0, 32'h0);
    chk("sat.end", 32'(busy), 32'h0);

    // Reset during a pending write.
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 1, 32'h4000_0060, 0, 32'h0);
    cyc(0, 0, 1, 32'h99, 0, 32'h0);
    chk("rstmid.req", 32'(bus_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_all("rstmid.async", 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 1, 32'h4000_0070, 1, 32'h0);
    cyc(0, 0, 1, 32'h1, 1, 32'h0);
    chk_all("rstmid.quiet", 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 0);
    cyc(1, 0, 0, 32'h0, 0, 32'h0);
    chk("rstmid.new_frame", 32'(busy), 32'h1);
    chk("rstmid.new_frame_req", 32'(bus_req), 32'h0);
    cyc(0, 1, 0, 32'h0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
